// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// uart_tx_arbiter: four one-byte holding slots sharing a single UART transmitter with an enforced inter-byte gap.
// Define UART_TX_ARB_RR_EN for round-robin selection; fixed priority (requester 0 highest) otherwise.
module uart_tx_arbiter #(
   parameter int GAP_CYCLES = 16
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [3:0]  req_valid,
   input  logic [31:0] req_data,
   output logic [3:0]  req_ready,
   input  logic        uart_busy,
   output logic        uart_en,
   output logic [7:0]  uart_data,
   output logic [1:0]  grant_id
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SEND = 3'd1,
      S_ARM  = 3'd2,
      S_WAIT = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] pending_q, pending_d;
   logic [3:0] accept;
   logic [7:0] slot_q [4];
   logic       arm_q, arm_d;
   logic [7:0] gap_q, gap_d;
   logic [7:0] data_q, data_d;
   logic [1:0] grant_q, grant_d;
   logic       win_found;
   logic [1:0] win_idx;

   assign accept    = req_valid & ~pending_q;
   assign req_ready = ~pending_q;
   assign uart_data = data_q;
   assign grant_id  = grant_q;

   generate
      for (genvar i = 0; i < 4; i++) begin : g_slot
         always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
               slot_q[i] <= 8'h00;
            end else if (accept[i]) begin
               slot_q[i] <= req_data[8*i +: 8];
            end
         end
      end
   endgenerate

`ifdef UART_TX_ARB_RR_EN
   logic [1:0] rr_q, rr_d;

   // Search starts one past the last grant so a busy requester cannot starve the others.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (!win_found && pending_q[rr_q + 2'(k)]) begin
            win_found = 1'b1;
            win_idx   = rr_q + 2'(k);
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rr_q <= 2'd0;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   always_comb begin
      win_found = 1'b0;
      win_idx   = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (pending_q[k]) begin
            win_found = 1'b1;
            win_idx   = 2'(k);
         end
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q | accept;
      arm_d     = arm_q;
      gap_d     = gap_q;
      data_d    = data_q;
      grant_d   = grant_q;
      uart_en   = 1'b0;
`ifdef UART_TX_ARB_RR_EN
      rr_d      = rr_q;
`endif
      case (state_q)
         S_IDLE: begin
            // A winner is always pending, hence never accepting on this edge.
            if (win_found) begin
               data_d             = slot_q[win_idx];
               grant_d            = win_idx;
               pending_d[win_idx] = 1'b0;
               state_d            = S_SEND;
`ifdef UART_TX_ARB_RR_EN
               rr_d               = win_idx + 2'd1;
`endif
            end
         end
         S_SEND: begin
            uart_en = 1'b1;
            arm_d   = 1'b0;
            state_d = S_ARM;
         end
         S_ARM: begin
            // Blind window covering the transmitter's busy-rise latency.
            if (arm_q) begin
               state_d = S_WAIT;
            end else begin
               arm_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (!uart_busy) begin
               if (GAP_CYCLES == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_GAP;
                  gap_d   = 8'(GAP_CYCLES - 1);
               end
            end
         end
         S_GAP: begin
            if (gap_q == 8'd0) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= S_IDLE;
         pending_q <= 4'b0000;
         arm_q     <= 1'b0;
         gap_q     <= 8'd0;
         data_q    <= 8'h00;
         grant_q   <= 2'd0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         arm_q     <= arm_d;
         gap_q     <= gap_d;
         data_q    <= data_d;
         grant_q   <= grant_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 16: idle cycles enforced between consecutive transmitted bytes (0..255).
REQ-002 sys_clk  input  1  single system clock (50 MHz); all logic on its rising edge.
REQ-003 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  4  per-requester byte offer; bit i belongs to requester i.
REQ-005 req_data  input  32  packed bytes; requester i uses bits [8i+7:8i].
REQ-006 req_ready  output  4  bit i high = requester i holding slot empty; transfer occurs when req_valid[i] & req_ready[i].
REQ-007 uart_busy  input  1  UART transmitter busy; rises no later than 2 cycles after uart_en, stays high until the byte and stop bit are done.
REQ-008 uart_en  output  1  one-cycle pulse launching a byte on the shared UART transmitter.
REQ-009 uart_data  output  8  byte to send; valid with uart_en and held stable until the next launch.
REQ-010 grant_id  output  2  index of requester whose byte was last launched.

Function
REQ-011 Each requester SHALL own a one-byte holding slot with a pending flag; req_ready[i] = ~pending[i].
REQ-012 A transfer SHALL set pending[i] and capture the byte on the same edge; req_valid while not ready SHALL be ignored (no overwrite).
REQ-013 The FSM SHALL have states IDLE, SEND, ARM, WAIT, GAP.
REQ-014 IDLE: if any pending bit is set, select a winner, load uart_data and grant_id, clear that pending bit, go to SEND; otherwise stay.
REQ-015 SEND: uart_en = 1 for exactly this one cycle; go to ARM.
REQ-016 ARM: lasts 2 cycles, ignoring uart_busy, then go to WAIT.
REQ-017 WAIT: stay while uart_busy = 1; on uart_busy = 0 go to GAP (or to IDLE if GAP_CYCLES = 0).
REQ-018 GAP: count GAP_CYCLES cycles, then go to IDLE; the counter SHALL reload on every entry.
REQ-019 Latency: a byte offered to an idle arbiter with all slots empty SHALL produce uart_en exactly 2 cycles after the transfer edge (slot capture, then IDLE select).
REQ-020 A slot cleared in IDLE SHALL show req_ready = 1 on the next cycle, so a requester can refill it while its previous byte transmits.
REQ-021 Simultaneous transfer into slot i and IDLE selection of slot i SHALL NOT occur, because a selected slot is always pending and therefore not ready.
REQ-022 uart_en SHALL never be asserted outside SEND, and never twice within one byte period.
REQ-023 The bits of uart_busy SHALL be used only in WAIT; uart_busy stuck high SHALL hold the FSM in WAIT without dropping any pending byte.

Reset
REQ-024 Reset SHALL force IDLE, all pending bits to 0, req_ready = 4'b1111, uart_en = 0, uart_data = 0, grant_id = 0, gap counter = 0, and the round-robin pointer to 0.
REQ-025 Reset asserted mid-byte SHALL discard all slots; no uart_en is issued until the first transfer after release.

Configuration
REQ-026 Macro UART_TX_ARB_RR_EN defined: round-robin selection, starting the search at (last grant_id + 1) mod 4; the pointer advances only on a grant.
REQ-027 Macro UART_TX_ARB_RR_EN undefined: fixed priority, with requester 0 highest and 3 lowest; the pointer logic is not compiled.

Verification
REQ-028 Single byte: GAP_CYCLES = 4, offer 0x61 on requester 2 to an idle arbiter -> uart_en 2 cycles later, uart_data = 0x61, grant_id = 2, req_ready[2] high 1 cycle after selection.
REQ-029 All four requesters offer 0x61/0x62/0x63/0x64 in the same cycle, with the UART model busy for 10 cycles -> with RR_EN the order is 0,1,2,3; without it the order is also 0,1,2,3; exactly 4 uart_en pulses, each separated by at least 2+10+GAP cycles.
REQ-030 RR fairness (RR_EN): requester 0 re-offers continuously while requester 3 holds 0x64 -> grants alternate 0,3,0,3; without RR_EN, requester 3 is served only when slot 0 is empty at the IDLE decision.
REQ-031 Full slot: offer 0x31 then 0x32 on requester 1 while uart_busy is held high -> 0x32 is not accepted (req_ready[1] = 0); after busy drops, 0x31 is sent first and 0x32 is accepted when offered again.
REQ-032 Stuck busy: hold uart_busy = 1 for 1000 cycles -> FSM stays in WAIT, no extra uart_en, pending bytes are preserved and are sent after release.
REQ-033 Reset in WAIT with 3 pending slots -> all outputs take their REQ-024 values within the reset assertion, and no uart_en appears after release until a new offer.
